fault_sim_sequencer: RTL and testbench

- Sequential controller that runs an exhaustive stuck-at fault campaign on a combinational circuit-under-test (CUT) that has opcode-driven fault injection, such as the c17 fault-simulation netlist.
- For every enabled fault it drives a fault opcode and all 2^N_IN input vectors to two CUT instances: a golden copy, whose opcode is tied to 0, and a faulty copy, which receives fault_opcode.
- It compares the two CUT outputs, records per-fault detection, and reports coverage.
- It is the parametrised successor to the single hard-wired c17 fault-injection netlist and sits above any CUT that uses the same opcode convention.

---
 rtl/fsim_pkg.sv | 26 ++
 rtl/fsim_iter.sv | 74 +++++++
 rtl/fault_sim_sequencer.sv | 129 ++++++++++++
 tb/tb_fault_sim_sequencer.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fsim_pkg.sv
// Shared types and helpers for the fault-simulation sequencer.
package fsim_pkg;

    typedef enum logic [1:0] {IDLE, LOAD, APPLY, FIN} fsim_state_e;

    // c17 sites: nets 1,2,3,6,7,8,9,10,11,14,15,16,19,20,21,22,23
    localparam logic [23:0] C17_SITE_MASK = 24'hF9CFCE;

    function automatic int unsigned fault_opc(input int unsigned net, input logic sa);
        return {net[30:0], sa};
    endfunction

    function automatic int unsigned popcount(input logic [63:0] m);
        int unsigned n;
        n = 0;
        for (int i = 0; i < 64; i++) n += 32'(m[i]);
        return n;
    endfunction

    // Lowest fault site; net 0 never carries a fault, so 0 also means "no sites".
    function automatic int unsigned first_site(input logic [63:0] m);
        for (int i = 1; i < 64; i++) if (m[i]) return unsigned'(i);
        return 0;
    endfunction

endpackage

// File: rtl/fsim_iter.sv
// Nested fault / vector / settle counter with a search for the next enabled fault site.
module fsim_iter import fsim_pkg::*; #(
    parameter int               N_IN       = 5,
    parameter int               NUM_NETS   = 23,
    parameter logic [NUM_NETS:0] SITE_MASK = '0,
    parameter int               SETTLE_CYC = 1,
    parameter int               NET_W      = $clog2(NUM_NETS + 1)
)(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             step,
    input  logic             skip,
    output logic [NET_W-1:0] net_id,
    output logic             stuck_val,
    output logic [N_IN-1:0]  vec,
    output logic             sample,
    output logic             last_fault,
    output logic             fault_adv
);
    localparam logic [3:0]       SETTLE_TOP = 4'(SETTLE_CYC - 1);
    localparam logic [NET_W-1:0] FIRST_NET  = NET_W'(first_site(64'(SITE_MASK)));
    localparam logic [N_IN-1:0]  VEC_TOP    = '1;

    logic [3:0]       settle_cnt;
    logic [NET_W-1:0] next_net;
    logic             has_next;
    logic             last_vec;

    // Descending scan so the lowest enabled net above the current one wins.
    always_comb begin
        next_net = net_id;
        has_next = 1'b0;
        for (int k = NUM_NETS; k >= 1; k--) begin
            if (SITE_MASK[k] && (k > int'(net_id))) begin
                next_net = NET_W'(k);
                has_next = 1'b1;
            end
        end
    end

    assign sample     = (settle_cnt == 4'd0);
    assign last_vec   = (vec == VEC_TOP);
    assign last_fault = stuck_val & ~has_next;
    assign fault_adv  = step & sample & (last_vec | skip);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            settle_cnt <= '0;
            net_id     <= '0;
            stuck_val  <= 1'b0;
            vec        <= '0;
        end else if (load) begin
            settle_cnt <= SETTLE_TOP;
            net_id     <= FIRST_NET;
            stuck_val  <= 1'b0;
            vec        <= '0;
        end else if (step) begin
            settle_cnt <= sample ? SETTLE_TOP : settle_cnt - 4'd1;
            if (fault_adv) begin
                vec <= '0;
                if (!stuck_val) begin
                    stuck_val <= 1'b1;
                end else if (has_next) begin
                    net_id    <= next_net;
                    stuck_val <= 1'b0;
                end
            end else if (sample) begin
                vec <= vec + N_IN'(1);
            end
        end
    end

endmodule

// File: rtl/fault_sim_sequencer.sv
// Exhaustive stuck-at campaign controller driving a golden and a faulty CUT copy.
//   state | meaning
//   IDLE  | waiting for start, results of last campaign held
//   LOAD  | clear results, select first fault
//   APPLY | drive opcode/vector, compare on last settle cycle
//   FIN   | one-cycle done pulse, outputs parked at 0
module fault_sim_sequencer import fsim_pkg::*; #(
    parameter int                N_IN       = 5,
    parameter int                N_OUT      = 2,
    parameter int                NUM_NETS   = 23,
    parameter logic [NUM_NETS:0] SITE_MASK  = (NUM_NETS + 1)'(C17_SITE_MASK),
    parameter int                SETTLE_CYC = 1,
    parameter int                OPC_W      = $clog2(NUM_NETS + 1) + 1
)(
    input  logic                                   clk,
    input  logic                                   rst_n,
    input  logic                                   start,
    input  logic                                   abort,
    input  logic                                   early_exit,
    output logic [OPC_W-1:0]                       fault_opcode,
    output logic [N_IN-1:0]                        test_vec,
    input  logic [N_OUT-1:0]                       golden_out,
    input  logic [N_OUT-1:0]                       faulty_out,
    output logic                                   busy,
    output logic                                   done,
    output logic                                   aborted,
    output logic [2*(NUM_NETS+1)-1:0]              detected,
    output logic [$clog2(2*(NUM_NETS+1)+1)-1:0]    det_count
);
    localparam int   NET_W     = OPC_W - 1;
    localparam int   DC_W      = $clog2(2 * (NUM_NETS + 1) + 1);
    localparam int   F_TOTAL   = 2 * int'(popcount(64'(SITE_MASK)));
    localparam logic HAS_SITES = (F_TOTAL != 0);

    fsim_state_e      state, state_nxt;
    logic             ee_lat;
    logic             iter_load, iter_step;
    logic [NET_W-1:0] net_id;
    logic             stuck_val;
    logic [N_IN-1:0]  vec;
    logic             sample, last_fault, fault_adv;
    logic [OPC_W-1:0] opc;
    logic             mismatch, record;

    fsim_iter #(
        .N_IN       (N_IN),
        .NUM_NETS   (NUM_NETS),
        .SITE_MASK  (SITE_MASK),
        .SETTLE_CYC (SETTLE_CYC),
        .NET_W      (NET_W)
    ) u_iter (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (iter_load),
        .step       (iter_step),
        .skip       (ee_lat & mismatch),
        .net_id     (net_id),
        .stuck_val  (stuck_val),
        .vec        (vec),
        .sample     (sample),
        .last_fault (last_fault),
        .fault_adv  (fault_adv)
    );

    assign opc      = OPC_W'(fault_opc(32'(net_id), stuck_val));
    assign mismatch = (golden_out != faulty_out);
    assign record   = iter_step & sample & mismatch & ~detected[opc];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = LOAD;
            LOAD:    state_nxt = (abort || !HAS_SITES) ? FIN : APPLY;
            APPLY:   if (abort || (fault_adv && last_fault)) state_nxt = FIN;
            FIN:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy         = 1'b0;
        done         = 1'b0;
        iter_load    = 1'b0;
        iter_step    = 1'b0;
        fault_opcode = '0;
        test_vec     = '0;
        case (state)
            LOAD: begin
                busy      = 1'b1;
                iter_load = 1'b1;
            end
            APPLY: begin
                busy         = 1'b1;
                iter_step    = 1'b1;
                fault_opcode = opc;
                test_vec     = vec;
            end
            FIN:     done = 1'b1;
            default: ;
        endcase
    end

    // A compare on the abort cycle still lands; the abort flag is set after the LOAD clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            detected  <= '0;
            det_count <= '0;
            aborted   <= 1'b0;
            ee_lat    <= 1'b0;
        end else begin
            if (state == IDLE && start) ee_lat <= early_exit;
            if (state == LOAD) begin
                detected  <= '0;
                det_count <= '0;
                aborted   <= 1'b0;
            end else if (record) begin
                detected[opc] <= 1'b1;
                if (det_count != DC_W'(F_TOTAL)) det_count <= det_count + DC_W'(1);
            end
            if ((state == LOAD || state == APPLY) && abort) aborted <= 1'b1;
        end
    end

endmodule

// File: tb/tb_fault_sim_sequencer.sv
// Bench for fault_sim_sequencer: c17 model with fault injection and a campaign-level reference model.
`timescale 1ns/1ps
module tb_fault_sim_sequencer;
    localparam logic [23:0] MASK_A  = 24'hF9CFCE;
    localparam logic [23:0] MASK_B  = 24'h000002;
    localparam logic [47:0] C17_DET = 48'hFFC3_F0FF_F0FC;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        start_a = 1'b0, abort_a = 1'b0, ee_a = 1'b0;
    logic [5:0]  fo_a;
    logic [4:0]  tv_a;
    logic [1:0]  gold_a, faulty_a;
    logic        busy_a, done_a, ab_a;
    logic [47:0] det_a;
    logic [5:0]  dc_a;

    logic        start_b = 1'b0, abort_b = 1'b0, ee_b = 1'b0;
    logic [5:0]  fo_b;
    logic [4:0]  tv_b;
    logic [1:0]  gold_b, faulty_b;
    logic [1:0]  glitch_b = 2'b00;
    logic        busy_b, done_b, ab_b;
    logic [47:0] det_b;
    logic [5:0]  dc_b;

    int          mode_a = 0;
    logic [1:0]  rtab [64][32];
    int          errors = 0;
    int          checks = 0;

    int unsigned exp_seq[$];
    logic [47:0] exp_det;
    int          exp_lat;
    int          n_eff;
    logic        exp_ab;

    function automatic logic inj(input int net, input logic v, input logic [5:0] opc);
        if (int'(opc[5:1]) == net) return opc[0];
        return v;
    endfunction

    // c17 with fanout branches as separate nets; input x[0] is net 1
    function automatic logic [1:0] c17(input logic [4:0] x, input logic [5:0] opc);
        logic n1, n2, n3, n6, n7, n8, n9, n10, n11, n14, n15, n16, n19, n20, n21, n22, n23;
        n1  = inj(1, x[0], opc);
        n2  = inj(2, x[1], opc);
        n3  = inj(3, x[2], opc);
        n6  = inj(6, x[3], opc);
        n7  = inj(7, x[4], opc);
        n8  = inj(8, n3, opc);
        n9  = inj(9, n3, opc);
        n10 = inj(10, ~(n1 & n8), opc);
        n11 = inj(11, ~(n9 & n6), opc);
        n14 = inj(14, n11, opc);
        n15 = inj(15, n11, opc);
        n16 = inj(16, ~(n2 & n14), opc);
        n19 = inj(19, ~(n15 & n7), opc);
        n20 = inj(20, n16, opc);
        n21 = inj(21, n16, opc);
        n22 = inj(22, ~(n10 & n20), opc);
        n23 = inj(23, ~(n21 & n19), opc);
        return {n23, n22};
    endfunction

    always_comb gold_a = c17(tv_a, 6'd0);
    always_comb begin
        case (mode_a)
            0:       faulty_a = c17(tv_a, fo_a);
            1:       faulty_a = gold_a;
            2:       faulty_a = ~gold_a;
            default: faulty_a = gold_a ^ rtab[fo_a][tv_a];
        endcase
    end
    always_comb gold_b = c17(tv_b, 6'd0);
    assign faulty_b = gold_b ^ glitch_b;

    fault_sim_sequencer #(.N_IN(5), .N_OUT(2), .NUM_NETS(23), .SITE_MASK(MASK_A),
                          .SETTLE_CYC(1), .OPC_W(6)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .start(start_a), .abort(abort_a), .early_exit(ee_a),
        .fault_opcode(fo_a), .test_vec(tv_a), .golden_out(gold_a), .faulty_out(faulty_a),
        .busy(busy_a), .done(done_a), .aborted(ab_a), .detected(det_a), .det_count(dc_a));

    fault_sim_sequencer #(.N_IN(5), .N_OUT(2), .NUM_NETS(23), .SITE_MASK(MASK_B),
                          .SETTLE_CYC(3), .OPC_W(6)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .start(start_b), .abort(abort_b), .early_exit(ee_b),
        .fault_opcode(fo_b), .test_vec(tv_b), .golden_out(gold_b), .faulty_out(faulty_b),
        .busy(busy_b), .done(done_b), .aborted(ab_b), .detected(det_b), .det_count(dc_b));

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic hit(input int mode, input logic [5:0] opc, input logic [4:0] v);
        case (mode)
            0:       return c17(v, opc) != c17(v, 6'd0);
            1:       return 1'b0;
            2:       return 1'b1;
            default: return rtab[opc][v] != 2'b00;
        endcase
    endfunction

    // Expected (opcode, vector, hit) per compare in campaign order, then truncated at abort.
    task automatic build_model(input int mode, input bit ee, input logic [23:0] mask, input int abort_k);
        logic h;
        exp_seq.delete();
        for (int net = 1; net <= 23; net++) begin
            if (mask[net]) begin
                for (int sa = 0; sa < 2; sa++) begin
                    for (int v = 0; v < 32; v++) begin
                        h = hit(mode, 6'(net * 2 + sa), 5'(v));
                        exp_seq.push_back(unsigned'((net * 2 + sa) * 32 + v + (h ? 2048 : 0)));
                        if (h && ee) break;
                    end
                end
            end
        end
        if (abort_k > 0 && abort_k < exp_seq.size() + 1) begin
            n_eff  = abort_k - 1;
            exp_ab = 1'b1;
        end else begin
            n_eff  = exp_seq.size();
            exp_ab = 1'b0;
        end
        exp_lat = n_eff + 2;
        exp_det = '0;
        for (int i = 0; i < n_eff; i++)
            if (exp_seq[i][11]) exp_det[exp_seq[i][10:5]] = 1'b1;
    endtask

    task automatic run_a(input string name, input int mode, input bit ee, input int abort_k, input int start_at);
        int          e, trace_err;
        bit          got_done;
        int unsigned ent;
        build_model(mode, ee, MASK_A, abort_k);
        mode_a = mode;
        ee_a   = ee;
        @(negedge clk);
        start_a = 1'b1;
        @(posedge clk);
        #1;
        start_a = 1'b0;
        ee_a    = ~ee;
        e = 0; trace_err = 0; got_done = 1'b0;
        while (!got_done && e < 4000) begin
            abort_a = (abort_k > 0 && e == abort_k - 1);
            start_a = (e == start_at);
            @(posedge clk);
            #1;
            e++;
            abort_a = 1'b0;
            start_a = 1'b0;
            if (done_a) got_done = 1'b1;
            else begin
                ent = (e - 1 < exp_seq.size()) ? exp_seq[e - 1] : 0;
                if (busy_a !== 1'b1 || fo_a !== 6'(ent >> 5) || tv_a !== 5'(ent)) trace_err++;
            end
        end
        check({name, "_done_seen"}, 64'(got_done), 64'd1);
        check({name, "_latency"}, 64'(e + 1), 64'(exp_lat));
        check({name, "_trace"}, 64'(trace_err), 64'd0);
        check({name, "_busy_end"}, 64'(busy_a), 64'd0);
        check({name, "_aborted"}, 64'(ab_a), 64'(exp_ab));
        check({name, "_detected"}, 64'(det_a), 64'(exp_det));
        check({name, "_det_count"}, 64'(dc_a), 64'($countones(exp_det)));
        check({name, "_opcode_fin"}, 64'(fo_a), 64'd0);
        check({name, "_vec_fin"}, 64'(tv_a), 64'd0);
        @(posedge clk);
        #1;
        check({name, "_done_pulse"}, 64'(done_a), 64'd0);
    endtask

    initial begin
        int         k_ab, vb, e, terr, idx, ph;
        bit         ee_r, got;
        logic [1:0] pb;

        for (int o = 0; o < 64; o++)
            for (int v = 0; v < 32; v++)
                rtab[o][v] = ($urandom_range(0, 39) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;

        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", 64'(busy_a), 64'd0);
        check("rst_done", 64'(done_a), 64'd0);
        check("rst_aborted", 64'(ab_a), 64'd0);
        check("rst_detected", 64'(det_a), 64'd0);
        check("rst_det_count", 64'(dc_a), 64'd0);
        check("rst_opcode", 64'(fo_a), 64'd0);
        check("rst_vec", 64'(tv_a), 64'd0);
        check("rst_b_busy", 64'(busy_b), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        run_a("c17_full", 0, 1'b0, 0, -1);
        check("c17_full_count34", 64'(dc_a), 64'd34);
        check("c17_full_bitmap", 64'(det_a), 64'(C17_DET));

        run_a("fault_free", 1, 1'b0, 0, -1);

        run_a("early_exit", 2, 1'b1, 0, -1);
        check("early_exit_count", 64'(dc_a), 64'd34);

        k_ab = $urandom_range(20, 1000);
        run_a("abort", 0, 1'b0, k_ab, 10);

        ee_r = 1'($urandom_range(0, 1));
        run_a("random_tab", 3, ee_r, 0, -1);

        @(negedge clk);
        start_a = 1'b1;
        @(posedge clk);
        #1;
        start_a = 1'b0;
        repeat (300) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("midrst_busy", 64'(busy_a), 64'd0);
        check("midrst_done", 64'(done_a), 64'd0);
        check("midrst_aborted", 64'(ab_a), 64'd0);
        check("midrst_detected", 64'(det_a), 64'd0);
        check("midrst_det_count", 64'(dc_a), 64'd0);
        check("midrst_opcode", 64'(fo_a), 64'd0);
        check("midrst_vec", 64'(tv_a), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run_a("rerun", 0, 1'b0, 0, -1);
        check("rerun_bitmap", 64'(det_a), 64'(C17_DET));

        // SETTLE_CYC=3: glitches on the first two hold cycles must be ignored
        vb = $urandom_range(0, 31);
        pb = 2'($urandom_range(1, 3));
        @(negedge clk);
        start_b = 1'b1;
        @(posedge clk);
        #1;
        start_b = 1'b0;
        e = 0; terr = 0; got = 1'b0;
        while (!got && e < 1000) begin
            @(posedge clk);
            #1;
            e++;
            if (done_b) got = 1'b1;
            else begin
                idx = (e - 1) / 3;
                ph  = (e - 1) % 3;
                if (busy_b !== 1'b1 || tv_b !== 5'(idx % 32) || fo_b !== 6'(2 + idx / 32)) terr++;
                glitch_b = (ph < 2) ? 2'b11 : ((fo_b == 6'd2 && tv_b == 5'(vb)) ? pb : 2'b00);
            end
        end
        glitch_b = 2'b00;
        check("settle_done_seen", 64'(got), 64'd1);
        check("settle_latency", 64'(e + 1), 64'd194);
        check("settle_hold", 64'(terr), 64'd0);
        check("settle_detected", 64'(det_b), 64'h4);
        check("settle_det_count", 64'(dc_b), 64'd1);
        check("settle_aborted", 64'(ab_b), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
